// File: rtl/register_file_dump.sv
// Register file with two combinational read ports, one synchronous write port
// and a valid/ready engine that streams every register out for trace logging.
module register_file_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  DumpStart,
  input  logic                  DumpReady,
  output logic                  DumpValid,
  output logic [ADDR_WIDTH-1:0] DumpAddr,
  output logic [DATA_WIDTH-1:0] DumpData,
  output logic                  DumpBusy,
  output logic                  DumpDone
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  writeEn;

  // With ZERO_REG the backing entry 0 is never written, so it stays at its reset value.
  assign writeEn = RegWrite && !((ZERO_REG != 0) && (WriteReg == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (writeEn) begin
      mem_q[WriteReg] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = mem_q[ReadReg1];
    if ((ZERO_REG != 0) && (ReadReg1 == '0)) begin
      ReadData1 = '0;
    end else if ((BYPASS != 0) && RegWrite && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
    end
  end

  always_comb begin
    ReadData2 = mem_q[ReadReg2];
    if ((ZERO_REG != 0) && (ReadReg2 == '0)) begin
      ReadData2 = '0;
    end else if ((BYPASS != 0) && RegWrite && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The dump path reads stored contents only; in-flight writes show up a cycle later.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    DumpValid = 1'b0;
    DumpBusy  = 1'b0;
    DumpDone  = 1'b0;
    DumpAddr  = '0;
    DumpData  = '0;
    case (state_q)
      IDLE: begin
        if (DumpStart) begin
          state_d = SEND;
          ptr_d   = '0;
        end
      end
      SEND: begin
        DumpValid = 1'b1;
        DumpBusy  = 1'b1;
        DumpAddr  = ptr_q;
        DumpData  = ((ZERO_REG != 0) && (ptr_q == '0)) ? '0 : mem_q[ptr_q];
        if (DumpReady) begin
          if (ptr_q == '1) begin
            state_d = DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        DumpDone = 1'b1;
        DumpBusy = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_register_file_dump.sv
// Self-checking bench: one instance with zero-reg/bypass enabled (dump checked),
// one with both disabled (read ports checked), against array models of the registers.
module tb_register_file_dump;

  logic        clock;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        DumpStart;
  logic        DumpReady;
  logic [31:0] rd1A, rd2A, rd1B, rd2B;
  logic        DumpValid, DumpBusy, DumpDone;
  logic [4:0]  DumpAddr;
  logic [31:0] DumpData;
  logic        dumpStartB, dumpReadyB;
  logic        dvB, dbB, ddB;
  logic [4:0]  daB;
  logic [31:0] ddataB;

  logic [31:0] modelA [32];
  logic [31:0] modelB [32];
  int checks;
  int errors;

  register_file_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clock(clock), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1A), .ReadData2(rd2A), .DumpStart(DumpStart), .DumpReady(DumpReady),
    .DumpValid(DumpValid), .DumpAddr(DumpAddr), .DumpData(DumpData),
    .DumpBusy(DumpBusy), .DumpDone(DumpDone)
  );

  register_file_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clock(clock), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1B), .ReadData2(rd2B), .DumpStart(dumpStartB), .DumpReady(dumpReadyB),
    .DumpValid(dvB), .DumpAddr(daB), .DumpData(ddataB),
    .DumpBusy(dbB), .DumpDone(ddB)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected read value from the register-file rules for either configuration.
  function automatic logic [31:0] expRead(input bit isA, input logic [4:0] idx);
    if (isA) begin
      if (idx == 5'd0) return 32'h0;
      if (RegWrite && WriteReg == idx) return WriteData;
      return modelA[idx];
    end
    return modelB[idx];
  endfunction

  task automatic clearModels();
    for (int i = 0; i < 32; i++) begin
      modelA[i] = 32'h0;
      modelB[i] = 32'h0;
    end
  endtask

  task automatic tick();
    if (RegWrite && !reset) begin
      if (WriteReg != 5'd0) modelA[WriteReg] = WriteData;
      modelB[WriteReg] = WriteData;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clearModels();
    #2;
    for (int k = 0; k < 3; k++) begin
      ReadReg1 = (k == 0) ? 5'd0 : (k == 1) ? 5'd5 : 5'd31;
      ReadReg2 = ReadReg1;
      #1;
      checks++;
      if (rd1A !== 32'h0 || rd2B !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_read idx=%0d got %h/%h exp 0", ReadReg1, rd1A, rd2B);
      end
    end
    checks++;
    if (DumpValid !== 1'b0 || DumpBusy !== 1'b0 || DumpDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dump got v=%b b=%b d=%b exp 000", DumpValid, DumpBusy, DumpDone);
    end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_write_bypass();
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd5;
    #1;
    checks++;
    if (rd1A !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_on got %h exp deadbeef", rd1A);
    end
    checks++;
    if (rd1B !== 32'h0) begin
      errors++;
      $display("[TB] FAIL bypass_off got %h exp 0", rd1B);
    end
    tick();
    RegWrite = 1'b0;
    #1;
    checks++;
    if (rd1A !== 32'hDEADBEEF || rd1B !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_stored got %h/%h exp deadbeef", rd1A, rd1B);
    end
  endtask

  task automatic test_zero_reg();
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; ReadReg2 = 5'd0;
    #1;
    checks++;
    if (rd2A !== 32'h0 || rd2B !== 32'h0) begin
      errors++;
      $display("[TB] FAIL zero_bypass got %h/%h exp 0/0", rd2A, rd2B);
    end
    tick();
    RegWrite = 1'b0;
    #1;
    checks++;
    if (rd2A !== 32'h0 || rd2B !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL zero_after got %h/%h exp 0/12345678", rd2A, rd2B);
    end
  endtask

  task automatic test_random_rw();
    for (int n = 0; n < 40; n++) begin
      RegWrite  = 1'($urandom_range(0, 1));
      WriteReg  = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      ReadReg1  = ($urandom_range(0, 1) == 1) ? WriteReg : 5'($urandom_range(0, 31));
      ReadReg2  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (rd1A !== expRead(1'b1, ReadReg1) || rd2A !== expRead(1'b1, ReadReg2)) begin
        errors++;
        $display("[TB] FAIL rand_readA r1=%0d r2=%0d got %h/%h exp %h/%h", ReadReg1, ReadReg2,
                 rd1A, rd2A, expRead(1'b1, ReadReg1), expRead(1'b1, ReadReg2));
      end
      checks++;
      if (rd1B !== expRead(1'b0, ReadReg1) || rd2B !== expRead(1'b0, ReadReg2)) begin
        errors++;
        $display("[TB] FAIL rand_readB r1=%0d r2=%0d got %h/%h exp %h/%h", ReadReg1, ReadReg2,
                 rd1B, rd2B, expRead(1'b0, ReadReg1), expRead(1'b0, ReadReg2));
      end
      tick();
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) begin
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = 32'(i * 3);
      tick();
    end
    RegWrite = 1'b0;
    DumpReady = 1'b1;
    DumpStart = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      DumpStart = (i == 10);
      #1;
      checks++;
      if (DumpValid !== 1'b1 || DumpBusy !== 1'b1 || DumpDone !== 1'b0 ||
          DumpAddr !== 5'(i) || DumpData !== 32'(i * 3)) begin
        errors++;
        $display("[TB] FAIL full_beat%0d got v=%b b=%b d=%b a=%0d data=%h exp 1 1 0 %0d %h",
                 i, DumpValid, DumpBusy, DumpDone, DumpAddr, DumpData, i, i * 3);
      end
      tick();
    end
    DumpStart = 1'b0;
    #1;
    checks++;
    if (DumpDone !== 1'b1 || DumpValid !== 1'b0 || DumpBusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_done got d=%b v=%b b=%b exp 1 0 1", DumpDone, DumpValid, DumpBusy);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (DumpDone !== 1'b0 || DumpValid !== 1'b0 || DumpBusy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL full_idle%0d got d=%b v=%b b=%b exp 000", k, DumpDone, DumpValid, DumpBusy);
      end
    end
  endtask

  task automatic test_backpressure();
    int waitCycles;
    for (int i = 0; i < 32; i++) begin
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = $urandom;
      tick();
    end
    RegWrite = 1'b0;
    DumpReady = 1'b1;
    DumpStart = 1'b1;
    tick();
    DumpStart = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    DumpReady = 1'b0;
    for (int s = 0; s < 4; s++) begin
      RegWrite = (s == 1); WriteReg = 5'd7; WriteData = 32'hAAAA0000;
      #1;
      checks++;
      if (DumpValid !== 1'b1 || DumpAddr !== 5'd7 || DumpData !== modelA[7] ||
          (s >= 2 && DumpData !== 32'hAAAA0000)) begin
        errors++;
        $display("[TB] FAIL stall%0d got v=%b a=%0d data=%h exp 1 7 %h", s, DumpValid, DumpAddr,
                 DumpData, modelA[7]);
      end
      tick();
    end
    RegWrite = 1'b0;
    DumpReady = 1'b1;
    tick();
    checks++;
    if (DumpAddr !== 5'd8 || DumpData !== modelA[8]) begin
      errors++;
      $display("[TB] FAIL release got a=%0d data=%h exp 8 %h", DumpAddr, DumpData, modelA[8]);
    end
    waitCycles = 0;
    while (DumpDone !== 1'b1 && waitCycles < 40) begin
      tick();
      waitCycles++;
    end
    checks++;
    if (DumpDone !== 1'b1 || waitCycles != 24) begin
      errors++;
      $display("[TB] FAIL bp_drain got done=%b after %0d cycles exp 1 after 24", DumpDone, waitCycles);
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    DumpReady = 1'b1;
    DumpStart = 1'b1;
    tick();
    DumpStart = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (DumpAddr !== 5'd12 || DumpValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset got a=%0d v=%b exp 12 1", DumpAddr, DumpValid);
    end
    ReadReg1 = 5'd7;
    ReadReg2 = 5'd31;
    #2 reset = 1'b1;
    clearModels();
    #1;
    checks++;
    if (DumpValid !== 1'b0 || DumpBusy !== 1'b0 || DumpDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_dump got v=%b b=%b d=%b exp 000", DumpValid, DumpBusy, DumpDone);
    end
    checks++;
    if (rd1A !== 32'h0 || rd2A !== 32'h0 || rd1B !== 32'h0 || rd2B !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_regs got %h %h %h %h exp 0", rd1A, rd2A, rd1B, rd2B);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (DumpDone !== 1'b0 || DumpBusy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset%0d got d=%b b=%b exp 0 0", k, DumpDone, DumpBusy);
      end
    end
    DumpStart = 1'b1;
    DumpReady = 1'b0;
    tick();
    DumpStart = 1'b0;
    checks++;
    if (DumpValid !== 1'b1 || DumpAddr !== 5'd0 || DumpData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL restart got v=%b a=%0d data=%h exp 1 0 0", DumpValid, DumpAddr, DumpData);
    end
    DumpReady = 1'b1;
    for (int k = 0; k < 33; k++) tick();
  endtask

  task automatic test_random_dump();
    int  beat;
    int  cycles;
    bit  accepted;
    beat = 0;
    cycles = 0;
    DumpReady = 1'b1;
    DumpStart = 1'b1;
    tick();
    DumpStart = 1'b0;
    while (beat < 32 && cycles < 400) begin
      DumpReady = 1'($urandom_range(0, 1));
      RegWrite  = 1'($urandom_range(0, 1));
      WriteReg  = ($urandom_range(0, 1) == 1) ? 5'(beat) : 5'($urandom_range(0, 31));
      WriteData = $urandom;
      #1;
      checks++;
      if (DumpValid !== 1'b1 || DumpAddr !== 5'(beat) ||
          DumpData !== ((beat == 0) ? 32'h0 : modelA[beat])) begin
        errors++;
        $display("[TB] FAIL rand_beat%0d got v=%b a=%0d data=%h exp 1 %0d %h", beat, DumpValid,
                 DumpAddr, DumpData, beat, (beat == 0) ? 32'h0 : modelA[beat]);
      end
      accepted = DumpReady;
      tick();
      if (accepted) beat++;
      cycles++;
    end
    RegWrite = 1'b0;
    #1;
    checks++;
    if (beat != 32 || DumpDone !== 1'b1 || DumpValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rand_done got beats=%0d done=%b v=%b exp 32 1 0", beat, DumpDone, DumpValid);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    DumpStart = 1'b0; DumpReady = 1'b0;
    dumpStartB = 1'b0; dumpReadyB = 1'b1;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_random_rw();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    test_random_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_dump.md
Name: register_file_dump

Overview:
Parametrised CPU register file: two asynchronous read ports, one synchronous write port, optional register-0 hardwiring and write-to-read bypass. Adds a serial dump engine that walks every register out over a valid/ready stream, replacing the old print-strobe mechanism. Sits in the decode stage of the single-cycle/pipelined datapath; the dump stream feeds the debug/trace logger.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = reads return stored value only

Ports:
clock  in  1  rising-edge clock for all state
reset  in  1  asynchronous, active-high; clears registers and dump FSM
RegWrite  in  1  write enable, sampled at posedge clock
WriteReg  in  ADDR_WIDTH  write index
WriteData  in  DATA_WIDTH  write data
ReadReg1  in  ADDR_WIDTH  read port 1 index
ReadReg2  in  ADDR_WIDTH  read port 2 index
ReadData1  out  DATA_WIDTH  read port 1 data (combinational)
ReadData2  out  DATA_WIDTH  read port 2 data (combinational)
DumpStart  in  1  request full register dump (pulse or level)
DumpReady  in  1  consumer ready for dump beat
DumpValid  out  1  dump beat valid
DumpAddr  out  ADDR_WIDTH  index of current dump beat
DumpData  out  DATA_WIDTH  contents of register DumpAddr
DumpBusy  out  1  dump in progress (SEND or DONE)
DumpDone  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async assert, sync-to-clock deassert by the system): all DEPTH registers = 0, FSM = IDLE, dump pointer = 0. All dump outputs 0. ReadData1/2 = 0, since the array is zero.
- Write: at posedge clock, if RegWrite and not (ZERO_REG and WriteReg==0), mem[WriteReg] <= WriteData. Writes are legal in every FSM state.
- Read port n: ReadReg n == 0 and ZERO_REG -> 0.
- Read port n, otherwise with BYPASS=1, RegWrite=1 and WriteReg==ReadReg n -> WriteData.
- Read port n, all other cases -> mem[ReadReg n].
- Reads have zero latency and change with any input or stored value.
- Dump FSM states: IDLE, SEND, DONE.
- IDLE: DumpValid=0, DumpBusy=0. DumpStart=1 -> SEND, ptr=0.
- SEND: DumpValid=1, DumpBusy=1, DumpAddr=ptr, DumpData=stored mem[ptr]. The dump path never bypasses. Register 0 reads 0 when ZERO_REG=1.
  - DumpData is combinational off the array. A write to mem[ptr] while stalled appears on DumpData the cycle after the write edge.
  - Beat accepted when DumpValid & DumpReady at posedge.
  - Accept with ptr < DEPTH-1 -> ptr+1, stay in SEND.
  - Accept with ptr == DEPTH-1 -> DONE, ptr=0. There is no wrap-around beat.
  - DumpReady=0 -> hold ptr, DumpAddr and DumpValid stable. Valid never drops without an accept.
- DONE: DumpDone=1, DumpBusy=1, DumpValid=0, for exactly one cycle -> IDLE unconditionally.
- DumpStart is ignored in SEND and DONE; no queuing. DumpStart held high continuously restarts the dump from IDLE the cycle after DONE.
- Minimum dump length with DumpReady tied high: DEPTH beats + 1 DONE cycle, i.e. DEPTH+1 cycles from the first SEND cycle.
- Reset mid-dump: immediate return to IDLE. DumpValid, DumpBusy and DumpDone drop asynchronously. No DumpDone pulse is emitted.

Test Plan:
- Reset then idle: assert reset, deassert -> ReadData1/2=0 for indices 0,5,31. DumpValid=0, DumpBusy=0.
- Write/read and bypass: RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF, ReadReg1=5 in the same cycle -> ReadData1=0xDEADBEEF before the edge (BYPASS=1); after the edge with RegWrite=0 -> still 0xDEADBEEF. Repeat with BYPASS=0 -> 0 before the edge, 0xDEADBEEF after.
- Zero register: write 0x12345678 to index 0 -> ReadData2 with ReadReg2=0 = 0, both in the bypass cycle and afterwards. Dump beat 0 data = 0.
- Full dump, no backpressure: preload mem[i]=i*3, pulse DumpStart, DumpReady=1 -> 32 consecutive beats with DumpAddr 0..31 and DumpData 0..93, then DumpDone high one cycle, then IDLE. DumpStart asserted mid-dump has no effect.
- Backpressure plus write: at DumpAddr=7, hold DumpReady=0 for 4 cycles and write mem[7]=0xAAAA0000 during the stall -> DumpAddr stays 7, DumpData shows 0xAAAA0000 from the cycle after the write. Release -> DumpAddr advances to 8.
- Reset mid-dump: assert reset at DumpAddr=12 -> DumpValid=0, DumpBusy=0 immediately, all registers 0, no DumpDone. A following DumpStart restarts at DumpAddr=0.
